modulo_gerenciador_rolhas_param: RTL and testbench

- Parametrised cork-supply manager for the filling/capping line.
- Owns two cork reservoirs: the secondary buffer, loaded by the operator, and the primary buffer, which feeds the capper.
- Accepts operator load requests with capacity checking. Moves corks from secondary to primary automatically, one per clock, whenever the primary drops below a threshold.
- Consumes one cork per capping event and produces the absence flag (ro) used by the filling/capping FSM.

---
 rtl/pkg_rolhas.sv | 21 ++
 rtl/modulo_detector_borda.sv | 31 +++
 rtl/modulo_gerenciador_rolhas_param.sv | 173 +++++++++++++++++
 tb/tb_modulo_gerenciador_rolhas_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_rolhas.sv
// -----------------------------------------------------------------------------
// pkg_rolhas
// Shared definitions for the cork-supply manager: the transfer FSM state
// encoding and the default line constants, so the manager and the display
// encoders agree on the same numbers.
// -----------------------------------------------------------------------------
package pkg_rolhas;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } estado_t;

    localparam int DEF_WIDTH        = 7;
    localparam int DEF_SEC_MAX      = 99;
    localparam int DEF_PRIM_MAX     = 20;
    localparam int DEF_PRIM_INIT    = 20;
    localparam int DEF_MIN_LEVEL    = 5;
    localparam int DEF_TRANSFER_QTY = 15;

endpackage

// File: rtl/modulo_detector_borda.sv
// -----------------------------------------------------------------------------
// modulo_detector_borda
// Rising-edge detector with a one-flop history.
// Ports:
//   clk     - clock
//   clr     - synchronous active-low reset, clears the history
//   sinal_i - level input
//   borda_o - high for the cycle in which sinal_i is 1 and the history is 0
// -----------------------------------------------------------------------------
module modulo_detector_borda (
    input  logic clk,
    input  logic clr,
    input  logic sinal_i,
    output logic borda_o
);

    logic historico_q;

    // The history always follows the input so that a level held across an
    // idle or frozen period never looks like a fresh edge afterwards.
    always_ff @(posedge clk) begin
        if (!clr) begin
            historico_q <= 1'b0;
        end else begin
            historico_q <= sinal_i;
        end
    end

    assign borda_o = sinal_i & ~historico_q;

endmodule

// File: rtl/modulo_gerenciador_rolhas_param.sv
// -----------------------------------------------------------------------------
// modulo_gerenciador_rolhas_param
// Cork-supply manager: a secondary buffer loaded by the operator and a
// primary buffer feeding the capper. Corks move secondary -> primary one per
// clock in bursts whenever the primary runs low.
// Ports:
//   clk, clr      - clock and synchronous active-low reset
//   enable        - 1 = operate, 0 = freeze all state
//   op_load       - operator load request level (acted on at rising edge)
//   op_qty        - corks in the operator load
//   cap_pulse     - one cork consumed by the capper
//   prim_count    - primary-buffer count
//   sec_count     - secondary-buffer count
//   ro            - primary buffer empty
//   transferring  - burst in progress
//   load_reject   - one-cycle pulse: load refused for lack of room
//   underflow     - one-cycle pulse: capper asked for a cork from an empty primary
// -----------------------------------------------------------------------------
module modulo_gerenciador_rolhas_param
    import pkg_rolhas::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int SEC_MAX      = DEF_SEC_MAX,
    parameter int PRIM_MAX     = DEF_PRIM_MAX,
    parameter int PRIM_INIT    = DEF_PRIM_INIT,
    parameter int MIN_LEVEL    = DEF_MIN_LEVEL,
    parameter int TRANSFER_QTY = DEF_TRANSFER_QTY
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             op_load,
    input  logic [WIDTH-1:0] op_qty,
    input  logic             cap_pulse,
    output logic [WIDTH-1:0] prim_count,
    output logic [WIDTH-1:0] sec_count,
    output logic             ro,
    output logic             transferring,
    output logic             load_reject,
    output logic             underflow
);

    if (PRIM_INIT > PRIM_MAX) begin : gen_chk_prim_init
        $error("PRIM_INIT must not exceed PRIM_MAX");
    end
    if (MIN_LEVEL > PRIM_MAX) begin : gen_chk_min_level
        $error("MIN_LEVEL must not exceed PRIM_MAX");
    end
    if (SEC_MAX >= (1 << WIDTH)) begin : gen_chk_sec_max
        $error("SEC_MAX must fit in WIDTH bits");
    end

    localparam logic [WIDTH:0]   SEC_MAX_W   = (WIDTH+1)'(SEC_MAX);
    localparam logic [WIDTH-1:0] PRIM_MAX_W  = WIDTH'(PRIM_MAX);
    localparam logic [WIDTH-1:0] PRIM_INIT_W = WIDTH'(PRIM_INIT);
    localparam logic [WIDTH-1:0] MIN_LEVEL_W = WIDTH'(MIN_LEVEL);
    localparam logic [WIDTH-1:0] XFER_QTY_W  = WIDTH'(TRANSFER_QTY);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] prim_q, prim_d;
    logic [WIDTH-1:0] sec_q, sec_d;
    logic [WIDTH-1:0] moved_q, moved_d;
    logic [WIDTH-1:0] pendQty_q, pendQty_d;
    logic             pending_q, pending_d;
    logic             loadReject_q, loadReject_d;
    logic             underflow_q, underflow_d;

    logic             loadEdge;
    logic             loadReq;
    logic [WIDTH-1:0] loadQty;
    logic [WIDTH:0]   loadSum;

    modulo_detector_borda u_borda_load (
        .clk     (clk),
        .clr     (clr),
        .sinal_i (op_load),
        .borda_o (loadEdge)
    );

    // A fresh edge in IDLE is serviced in the same cycle it is seen, and it
    // supersedes any older pending quantity. The sum is one bit wider so the
    // room check cannot be fooled by wrap-around.
    assign loadReq = loadEdge | pending_q;
    assign loadQty = loadEdge ? op_qty : pendQty_q;
    assign loadSum = {1'b0, sec_q} + {1'b0, loadQty};

    // Next-state logic. With enable low every register holds, including the
    // pulse outputs. In IDLE a load beats the start of a burst; in XFER each
    // cycle moves one cork, and a simultaneous cap leaves the primary net
    // unchanged (the incoming cork covers it, so no underflow is possible).
    always_comb begin
        state_d      = state_q;
        prim_d       = prim_q;
        sec_d        = sec_q;
        moved_d      = moved_q;
        pending_d    = pending_q;
        pendQty_d    = pendQty_q;
        loadReject_d = loadReject_q;
        underflow_d  = underflow_q;
        if (enable) begin
            loadReject_d = 1'b0;
            underflow_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (loadReq) begin
                        pending_d = 1'b0;
                        if (loadSum > SEC_MAX_W) begin
                            loadReject_d = 1'b1;
                        end else begin
                            sec_d = loadSum[WIDTH-1:0];
                        end
                    end else if ((prim_q < MIN_LEVEL_W) && (sec_q != '0)) begin
                        state_d = ST_XFER;
                        moved_d = '0;
                    end
                    if (cap_pulse) begin
                        if (prim_q != '0) begin
                            prim_d = prim_q - 1'b1;
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    if (loadEdge) begin
                        pending_d = 1'b1;
                        pendQty_d = op_qty;
                    end
                    sec_d   = sec_q - 1'b1;
                    moved_d = moved_q + 1'b1;
                    prim_d  = cap_pulse ? prim_q : prim_q + 1'b1;
                    if ((moved_d == XFER_QTY_W) || (sec_d == '0) || (prim_d >= PRIM_MAX_W)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register bank; reset drops any burst or pending load outright.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            prim_q       <= PRIM_INIT_W;
            sec_q        <= '0;
            moved_q      <= '0;
            pending_q    <= 1'b0;
            pendQty_q    <= '0;
            loadReject_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prim_q       <= prim_d;
            sec_q        <= sec_d;
            moved_q      <= moved_d;
            pending_q    <= pending_d;
            pendQty_q    <= pendQty_d;
            loadReject_q <= loadReject_d;
            underflow_q  <= underflow_d;
        end
    end

    assign prim_count   = prim_q;
    assign sec_count    = sec_q;
    assign ro           = (prim_q == '0);
    assign transferring = (state_q == ST_XFER);
    assign load_reject  = loadReject_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// -----------------------------------------------------------------------------
// tb_modulo_gerenciador_rolhas_param
// Directed bench for the cork-supply manager with default parameters.
// The stimulus process queues the expected outputs for the cycle following
// each set of inputs; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_modulo_gerenciador_rolhas_param;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         clr;
    logic         enable;
    logic         op_load;
    logic [W-1:0] op_qty;
    logic         cap_pulse;
    logic [W-1:0] prim_count;
    logic [W-1:0] sec_count;
    logic         ro;
    logic         transferring;
    logic         load_reject;
    logic         underflow;

    typedef struct {
        int           stamp;
        logic [W-1:0] prim;
        logic [W-1:0] sec;
        logic         ro;
        logic         xfer;
        logic         rej;
        logic         und;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    modulo_gerenciador_rolhas_param dut (
        .clk          (clk),
        .clr          (clr),
        .enable       (enable),
        .op_load      (op_load),
        .op_qty       (op_qty),
        .cap_pulse    (cap_pulse),
        .prim_count   (prim_count),
        .sec_count    (sec_count),
        .ro           (ro),
        .transferring (transferring),
        .load_reject  (load_reject),
        .underflow    (underflow)
    );

    // 10-time-unit clock and a count of rising edges seen so far.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on each falling edge, compare every expectation due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].stamp == cyc) begin
                checks++;
                if (prim_count !== sb[i].prim || sec_count !== sb[i].sec || ro !== sb[i].ro ||
                    transferring !== sb[i].xfer || load_reject !== sb[i].rej || underflow !== sb[i].und) begin
                    failures++;
                    $display("[TB] FAIL %s: got prim=%0d sec=%0d ro=%0b xfer=%0b rej=%0b und=%0b, expected prim=%0d sec=%0d ro=%0b xfer=%0b rej=%0b und=%0b",
                             sb[i].name, prim_count, sec_count, ro, transferring, load_reject, underflow,
                             sb[i].prim, sb[i].sec, sb[i].ro, sb[i].xfer, sb[i].rej, sb[i].und);
                end
                sb.delete(i);
            end
        end
    end

    // Drive one set of inputs; they take effect at the next rising edge.
    task automatic applyStimulus(input logic clrN, input logic en, input logic load,
                                 input int qty, input logic cap);
        clr       = clrN;
        enable    = en;
        op_load   = load;
        op_qty    = W'(qty);
        cap_pulse = cap;
    endtask

    // Queue the outputs expected right after the next rising edge.
    task automatic checkOutput(input string name, input int prim, input int sec,
                               input logic xfer, input logic rej, input logic und);
        exp_t e;
        e.stamp = cyc + 1;
        e.prim  = W'(prim);
        e.sec   = W'(sec);
        e.ro    = (prim == 0);
        e.xfer  = xfer;
        e.rej   = rej;
        e.und   = und;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input string name, input logic clrN, input logic en, input logic load,
                            input int qty, input logic cap, input int prim, input int sec,
                            input logic xfer, input logic rej, input logic und);
        applyStimulus(clrN, en, load, qty, cap);
        checkOutput(name, prim, sec, xfer, rej, und);
        tick();
    endtask

    // Directed scenario: reset, loads, bursts, boundaries, underflow, freeze.
    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);

        runCycle("rst_a", 0, 1, 0, 0, 0, 20, 0, 0, 0, 0);
        runCycle("rst_b", 0, 1, 0, 0, 0, 20, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            runCycle($sformatf("idle_%0d", i), 1, 1, 0, 0, 0, 20, 0, 0, 0, 0);

        runCycle("load60",       1, 1, 1, 60, 0, 20, 60, 0, 0, 0);
        runCycle("load60_hold",  1, 1, 1, 60, 0, 20, 60, 0, 0, 0);
        runCycle("load60_low",   1, 1, 0, 0,  0, 20, 60, 0, 0, 0);
        runCycle("load40_rej",   1, 1, 1, 40, 0, 20, 60, 0, 1, 0);
        runCycle("load40_after", 1, 1, 0, 0,  0, 20, 60, 0, 0, 0);

        for (int k = 1; k <= 16; k++)
            runCycle($sformatf("cap_a%0d", k), 1, 1, 0, 0, 1, 20 - k, 60, 0, 0, 0);
        for (int m = 0; m <= 15; m++)
            runCycle($sformatf("burst_a%0d", m), 1, 1, 0, 0, 0, 4 + m, 60 - m, (m < 15), 0, 0);
        runCycle("burst_a_done", 1, 1, 0, 0, 0, 19, 45, 0, 0, 0);

        runCycle("load54_full", 1, 1, 1, 54, 0, 19, 99, 0, 0, 0);
        runCycle("load54_low",  1, 1, 0, 0,  0, 19, 99, 0, 0, 0);
        runCycle("load1_over",  1, 1, 1, 1,  0, 19, 99, 0, 1, 0);
        runCycle("load1_low",   1, 1, 0, 0,  0, 19, 99, 0, 0, 0);

        runCycle("rst_c",    0, 1, 0, 0, 0, 20, 0, 0, 0, 0);
        runCycle("load3",    1, 1, 1, 3, 0, 20, 3, 0, 0, 0);
        runCycle("load3_low", 1, 1, 0, 0, 0, 20, 3, 0, 0, 0);
        for (int k = 1; k <= 16; k++)
            runCycle($sformatf("cap_b%0d", k), 1, 1, 0, 0, 1, 20 - k, 3, 0, 0, 0);
        for (int m = 0; m <= 3; m++)
            runCycle($sformatf("burst_b%0d", m), 1, 1, 0, 0, 0, 4 + m, 3 - m, (m < 3), 0, 0);
        for (int k = 1; k <= 3; k++)
            runCycle($sformatf("cap_c%0d", k), 1, 1, 0, 0, 1, 7 - k, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            runCycle($sformatf("nosec_%0d", i), 1, 1, 0, 0, 0, 4, 0, 0, 0, 0);

        runCycle("load30",     1, 1, 1, 30, 0, 4, 30, 0, 0, 0);
        runCycle("xfer_entry", 1, 1, 0, 0,  0, 4, 30, 1, 0, 0);
        for (int j = 1; j <= 15; j++)
            runCycle($sformatf("sim_%0d", j), 1, 1, (j >= 3), (j == 3) ? 10 : 77, 1,
                     4, 30 - j, (j < 15), 0, 0);
        runCycle("pending_applied", 1, 1, 1, 77, 0, 4, 25, 0, 0, 0);
        runCycle("xfer2_entry",     1, 1, 0, 0,  0, 4, 25, 1, 0, 0);
        runCycle("xfer2_m1",        1, 1, 0, 0,  0, 5, 24, 1, 0, 0);
        runCycle("xfer2_m2",        1, 1, 0, 0,  0, 6, 23, 1, 0, 0);
        runCycle("rst_mid_burst",   0, 1, 0, 0,  0, 20, 0, 0, 0, 0);
        runCycle("rst_mid_idle",    1, 1, 0, 0,  0, 20, 0, 0, 0, 0);

        for (int k = 1; k <= 20; k++)
            runCycle($sformatf("drain_%0d", k), 1, 1, 0, 0, 1, 20 - k, 0, 0, 0, 0);
        runCycle("underflow",       1, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        runCycle("underflow_end",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("disabled",        1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        runCycle("enabled_no_edge", 1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        runCycle("load2_low",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("load2",           1, 1, 1, 2, 0, 0, 2, 0, 0, 0);
        runCycle("xfer3_entry",     1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        runCycle("xfer3_cap",       1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        runCycle("xfer3_last",      1, 1, 0, 0, 0, 1, 0, 0, 0, 0);

        applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
